bp_resolve_unit: RTL

- Resolves branches that reach AGEX and produces the predictor update/redirect packet consumed by the branch predictor.
- FE pushes one prediction record per fetched instruction (PC, predicted next PC, BHR snapshot) into an in-order FIFO.
- AGEX pops the head record, evaluates the real outcome, and emits a registered update packet plus flush/redirect on mispredict.
- Also keeps branch and mispredict statistics counters.

---
 rtl/bp_resolve_unit_pkg.sv | 41 ++++
 rtl/bp_resolve_unit_pred_fifo.sv | 61 ++++++
 rtl/bp_resolve_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/bp_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit and the branch predictor.
// Holds the widths, the ex_op encoding and the layout of the update packet,
// so both sides agree on field order.
package bp_resolve_unit_pkg;

  localparam int DBITS    = 32;
  localparam int BHR_BITS = 8;
  localparam int INSTSIZE = 4;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_BEQ  = 3'd1,
    OP_BNE  = 3'd2,
    OP_BLT  = 3'd3,
    OP_BGE  = 3'd4,
    OP_BLTU = 3'd5,
    OP_BGEU = 3'd6,
    OP_JUMP = 3'd7
  } ex_op_e;

  // Field order is MSB first: {is_branch, taken, actual_next_pc, bhr, pc}
  typedef struct packed {
    logic                is_branch;
    logic                taken;
    logic [DBITS-1:0]    actual_next_pc;
    logic [BHR_BITS-1:0] bhr;
    logic [DBITS-1:0]    pc;
  } bp_upd_t;

  localparam int UPD_W = 2 + 2*DBITS + BHR_BITS;

  // One in-flight prediction made by FE
  typedef struct packed {
    logic [DBITS-1:0]    pc;
    logic [DBITS-1:0]    pred_pc;
    logic [BHR_BITS-1:0] bhr;
  } pred_rec_t;

  localparam int REC_W = $bits(pred_rec_t);

endpackage

// File: rtl/bp_resolve_unit_pred_fifo.sv
// bp_pred_fifo: generic synchronous FIFO with a synchronous clear.
// Ports:
//   clk, reset (sync, active-low)
//   clear          empties the FIFO and drops a same-cycle push
//   push, wdata    write side; a push when full is accepted only with a pop
//   pop, rdata     read side; rdata shows the head, pop on empty is ignored
//   full, empty    status
module bp_pred_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign do_push = push && !clear && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bp_resolve_unit.sv
// bp_resolve_unit: resolves branches in AGEX against the prediction FE made
// and produces the registered predictor update / redirect packet.
// Ports:
//   clk, reset (sync, active-low)
//   fe_push, fe_pc, fe_pred_pc, fe_bhr   prediction record from FE
//   fe_stall                             record FIFO full
//   ex_valid, ex_pc, ex_op, ex_rs1,
//   ex_rs2, ex_target                    instruction resolving in AGEX
//   bp_upd                               one-cycle update packet to predictor
//   flush, redirect_pc                   mispredict redirect, one cycle
//   seq_err                              sticky FE/AGEX ordering error
//   n_branches, n_mispred                statistics, wrap at 2^32
module bp_resolve_unit
  import bp_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fe_push,
  input  logic [DBITS-1:0]    fe_pc,
  input  logic [DBITS-1:0]    fe_pred_pc,
  input  logic [BHR_BITS-1:0] fe_bhr,
  output logic                fe_stall,
  input  logic                ex_valid,
  input  logic [DBITS-1:0]    ex_pc,
  input  logic [2:0]          ex_op,
  input  logic [DBITS-1:0]    ex_rs1,
  input  logic [DBITS-1:0]    ex_rs2,
  input  logic [DBITS-1:0]    ex_target,
  output logic [UPD_W-1:0]    bp_upd,
  output logic                flush,
  output logic [DBITS-1:0]    redirect_pc,
  output logic                seq_err,
  output logic [31:0]         n_branches,
  output logic [31:0]         n_mispred
);

  pred_rec_t        wr_rec;
  pred_rec_t        head;
  logic [REC_W-1:0] head_raw;
  logic             fifo_empty;
  logic             resolve;
  logic             taken;
  logic             is_branch;
  logic [DBITS-1:0] actual_next;
  logic             mispredict;
  bp_upd_t          upd_next;

  assign wr_rec = '{pc: fe_pc, pred_pc: fe_pred_pc, bhr: fe_bhr};

  bp_pred_fifo #(
    .WIDTH(REC_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (mispredict),
    .push  (fe_push),
    .wdata (wr_rec),
    .pop   (ex_valid),
    .rdata (head_raw),
    .full  (fe_stall),
    .empty (fifo_empty)
  );

  assign head    = pred_rec_t'(head_raw);
  assign resolve = ex_valid && !fifo_empty;

  always_comb begin
    taken = 1'b0;
    case (ex_op)
      OP_BEQ:  taken = (ex_rs1 == ex_rs2);
      OP_BNE:  taken = (ex_rs1 != ex_rs2);
      OP_BLT:  taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      OP_BGE:  taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      OP_BLTU: taken = (ex_rs1 <  ex_rs2);
      OP_BGEU: taken = (ex_rs1 >= ex_rs2);
      OP_JUMP: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign is_branch   = (ex_op != OP_NONE);
  assign actual_next = taken ? ex_target : ex_pc + DBITS'(INSTSIZE);
  // Non-branches are checked too: FE may have predicted a taken branch there
  assign mispredict  = resolve && (actual_next != head.pred_pc);

  assign upd_next = '{is_branch:      is_branch,
                      taken:          taken,
                      actual_next_pc: actual_next,
                      bhr:            head.bhr,
                      pc:             ex_pc};

  always_ff @(posedge clk) begin
    if (!reset) begin
      bp_upd      <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      seq_err     <= 1'b0;
      n_branches  <= '0;
      n_mispred   <= '0;
    end else begin
      bp_upd      <= resolve ? upd_next : '0;
      flush       <= mispredict;
      redirect_pc <= mispredict ? actual_next : '0;
      if (ex_valid && (fifo_empty || head.pc != ex_pc)) seq_err <= 1'b1;
      if (resolve) begin
        n_branches <= n_branches + 32'(is_branch);
        n_mispred  <= n_mispred + 32'(mispredict && is_branch);
      end
    end
  end

endmodule
